// File: rtl/burst_sram_ctrl.sv
// burst_sram_ctrl: sequences one burst command into one SRAM access per beat.
// Latency: accept in cycle 0, first SRAM access in cycle 1; an N-beat read returns rvalid in cycles 2..N+1, with done in cycle N+1.
// Backpressure: req_ready only while idle; wvalid low stalls a write burst; read data has no backpressure.
// Ports: clk/rst (sync, active-high), req_* command channel, wdata/wvalid/wready write stream,
//        rdata/rvalid read stream, sram_* single-port SRAM side, busy/done/err status.
// Option: define BURST_STRIDE_EN for a strided burst (address step STRIDE_LEN); otherwise the step is 1.
module burst_sram_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 15,
    parameter int STRIDE_LEN = 8,
    localparam int LEN_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Reject nonsensical parameter sets at elaboration rather than in silicon.
    if (BURST_LEN < 1 || STRIDE_LEN < 1) begin : g_bad_param
        $error("burst_sram_ctrl: BURST_LEN and STRIDE_LEN must be at least 1");
    end

`ifdef BURST_STRIDE_EN
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRIDE_LEN);
`else
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(1);
`endif

    // RD issues beats 1..N-1; RD_LAST issues the final access so that the
    // last rvalid lands in the DONE cycle.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RD_LAST,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  rvalid_q, rvalid_d;
    logic                  len_ok;

    assign len_ok = (req_len != '0) && (int'(req_len) <= BURST_LEN);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        req_ready  = 1'b0;
        wready     = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_wdata = '0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    if (!len_ok) begin
                        err_d = 1'b1;
                    end else begin
                        ptr_d = req_addr;
                        cnt_d = req_len;
                        if (req_write)
                            state_d = S_WR;
                        else if (req_len == LEN_W'(1))
                            state_d = S_RD_LAST;
                        else
                            state_d = S_RD;
                    end
                end
            end
            S_WR: begin
                wready     = 1'b1;
                sram_en    = wvalid;
                sram_we    = wvalid;
                sram_wdata = wdata;
                if (wvalid) begin
                    ptr_d = ptr_q + STEP;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1))
                        state_d = S_DONE;
                end
            end
            S_RD: begin
                sram_en = 1'b1;
                ptr_d   = ptr_q + STEP;
                cnt_d   = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(2))
                    state_d = S_RD_LAST;
            end
            S_RD_LAST: begin
                sram_en = 1'b1;
                ptr_d   = ptr_q + STEP;
                cnt_d   = cnt_q - LEN_W'(1);
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A read access in this cycle yields valid SRAM data in the next one.
    assign rvalid_d = (state_q == S_RD) || (state_q == S_RD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign sram_addr = ptr_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rvalid_q ? sram_rdata : '0;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;

endmodule
